// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard/sequencing controller.
// FSM state encodings, EX-stage forwarding select codes and the halt instruction word.
// Pure declarations; no logic, no latency.
package pipe_ctrl_pkg;

  // halt-drain FSM states
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // instruction encoding that requests a halt
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard inputs from the datapath and stall/flush/forward controls back to it.
// Wires only, zero latency; no backpressure, all signals sampled every cycle.
// Optional perf counter outputs exist when PIPE_PERF_CNT_EN is defined.
interface pipeline_ctrl_if;
  logic [31:0] instr_d;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic [4:0]  rs_e;
  logic [4:0]  rt_e;
  logic        regwrite_e;
  logic        memtoreg_e;
  logic [4:0]  writereg_e;
  logic        regwrite_m;
  logic [4:0]  writereg_m;
  logic        regwrite_w;
  logic [4:0]  writereg_w;
  logic        branch_taken_m;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        flush_e;
  logic        flush_m;
  logic [1:0]  fwd_a_e;
  logic [1:0]  fwd_b_e;
  logic        halted;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  // controller side: consumes hazard info, drives controls
  modport master (
    input  instr_d, rs_d, rt_d, rs_e, rt_e, regwrite_e, memtoreg_e, writereg_e,
           regwrite_m, writereg_m, regwrite_w, writereg_w, branch_taken_m,
    output stall_f, stall_d, flush_d, flush_e, flush_m, fwd_a_e, fwd_b_e, halted
`ifdef PIPE_PERF_CNT_EN
    , output cyc_cnt, stall_cnt, flush_cnt
`endif
  );

  // datapath side: supplies hazard info, obeys controls
  modport slave (
    output instr_d, rs_d, rt_d, rs_e, rt_e, regwrite_e, memtoreg_e, writereg_e,
           regwrite_m, writereg_m, regwrite_w, writereg_w, branch_taken_m,
    input  stall_f, stall_d, flush_d, flush_e, flush_m, fwd_a_e, fwd_b_e, halted
`ifdef PIPE_PERF_CNT_EN
    , input cyc_cnt, stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Forwarding select for one EX source operand.
// Combinational, zero latency; no backpressure.
// MEM result beats WB result; register $0 is never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       regwrite_m,
  input  logic [4:0] writereg_m,
  input  logic       regwrite_w,
  input  logic [4:0] writereg_w,
  output logic [1:0] sel
);

  // priority compare: MEM stage first, then WB, else register file
  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && (writereg_m != 5'd0) && (writereg_m == src))
      sel = FWD_MEM;
    else if (regwrite_w && (writereg_w != 5'd0) && (writereg_w == src))
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, EX forwarding and halt-drain FSM.
// Controls are combinational from current inputs and FSM state; FSM updates on CLK.
// No backpressure of its own; it is the source of stall/flush for the pipeline.
// Optional perf counters (cyc/stall/flush) are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] HALT_WORD    = pipe_ctrl_pkg::HALT_WORD
) (
  input  logic            CLK,
  input  logic            RESET,
  pipeline_ctrl_if.master bus
);
  import pipe_ctrl_pkg::*;

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  logic [1:0]    state;
  logic [CW-1:0] drain_cnt;
  logic          lu;
  logic          halt_req;

  fwd_unit u_fwd_a (
    .src(bus.rs_e), .regwrite_m(bus.regwrite_m), .writereg_m(bus.writereg_m),
    .regwrite_w(bus.regwrite_w), .writereg_w(bus.writereg_w), .sel(bus.fwd_a_e)
  );

  fwd_unit u_fwd_b (
    .src(bus.rt_e), .regwrite_m(bus.regwrite_m), .writereg_m(bus.writereg_m),
    .regwrite_w(bus.regwrite_w), .writereg_w(bus.writereg_w), .sel(bus.fwd_b_e)
  );

  // load-use hazard and halt request, only meaningful while running
  always_comb begin
    lu = (state == RUN) && bus.regwrite_e && bus.memtoreg_e && (bus.writereg_e != 5'd0) &&
         ((bus.writereg_e == bus.rs_d) || (bus.writereg_e == bus.rt_d));
    halt_req = (state == RUN) && (bus.instr_d == HALT_WORD) && !bus.branch_taken_m && !lu;
  end

  // stall/flush decode; a taken branch overrides everything except a finished halt
  always_comb begin
    bus.stall_f = 1'b0;
    bus.stall_d = 1'b0;
    bus.flush_d = 1'b0;
    bus.flush_e = 1'b0;
    bus.flush_m = 1'b0;
    case (state)
      RUN: begin
        if (lu) begin
          bus.stall_f = 1'b1;
          bus.stall_d = 1'b1;
          bus.flush_e = 1'b1;
        end
        // keep the halt word from ever reaching EX
        if (halt_req) bus.flush_e = 1'b1;
      end
      DRAIN: begin
        bus.stall_f = 1'b1;
        bus.flush_d = 1'b1;
      end
      HALTED: begin
        bus.stall_f = 1'b1;
        bus.stall_d = 1'b1;
        bus.flush_e = 1'b1;
        bus.flush_m = 1'b1;
      end
      default: ;
    endcase
    // the load-use or halt instruction behind a taken branch is wrong-path
    if (bus.branch_taken_m && (state != HALTED)) begin
      bus.flush_d = 1'b1;
      bus.flush_e = 1'b1;
      bus.flush_m = 1'b1;
      bus.stall_f = 1'b0;
      bus.stall_d = 1'b0;
    end
  end

  assign bus.halted = (state == HALTED);

  // halt-drain FSM: let older instructions retire, abort if the halt was wrong-path
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (bus.branch_taken_m) begin
            state     <= RUN;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
            if (drain_cnt == CW'(DRAIN_CYCLES - 1)) state <= HALTED;
          end
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // performance counters, frozen once halted, wrap naturally
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.cyc_cnt   <= '0;
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else if (state != HALTED) begin
      bus.cyc_cnt <= bus.cyc_cnt + 32'd1;
      if (lu)                 bus.stall_cnt <= bus.stall_cnt + 32'd1;
      if (bus.branch_taken_m) bus.flush_cnt <= bus.flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Covers forwarding, load-use, branch override, halt drain/abort and async reset.
module tb_pipeline_ctrl;
  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.DRAIN_CYCLES(3)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.instr_d        = 32'h0;
    bus.rs_d           = 5'd0;
    bus.rt_d           = 5'd0;
    bus.rs_e           = 5'd0;
    bus.rt_e           = 5'd0;
    bus.regwrite_e     = 1'b0;
    bus.memtoreg_e     = 1'b0;
    bus.writereg_e     = 5'd0;
    bus.regwrite_m     = 1'b0;
    bus.writereg_m     = 5'd0;
    bus.regwrite_w     = 1'b0;
    bus.writereg_w     = 5'd0;
    bus.branch_taken_m = 1'b0;
  endtask

  // next falling edge, then settle
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET  = 1'b1;
    idle_inputs();
    #12;
    chk("rst_halted",  32'(bus.halted),  32'd0);
    chk("rst_stall_f", 32'(bus.stall_f), 32'd0);
    chk("rst_flush_e", 32'(bus.flush_e), 32'd0);
    chk("rst_fwd_a",   32'(bus.fwd_a_e), 32'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("rst_cyc_cnt", bus.cyc_cnt, 32'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;

    // forwarding: MEM match on both operands
    bus.rs_e = 5'd8; bus.rt_e = 5'd8; bus.regwrite_m = 1'b1; bus.writereg_m = 5'd8;
    #1;
    chk("fwd_a_mem", 32'(bus.fwd_a_e), 32'h2);
    chk("fwd_b_mem", 32'(bus.fwd_b_e), 32'h2);
    // WB only
    step();
    bus.regwrite_m = 1'b0; bus.regwrite_w = 1'b1; bus.writereg_w = 5'd8;
    #1;
    chk("fwd_a_wb", 32'(bus.fwd_a_e), 32'h1);
    // MEM and WB both match: MEM wins
    step();
    bus.regwrite_m = 1'b1;
    #1;
    chk("fwd_a_prio", 32'(bus.fwd_a_e), 32'h2);
    // $0 never forwarded
    step();
    bus.rs_e = 5'd0; bus.writereg_m = 5'd0; bus.writereg_w = 5'd0;
    #1;
    chk("fwd_a_r0", 32'(bus.fwd_a_e), 32'h0);
    // no write enable on a matching register
    step();
    bus.rt_e = 5'd12; bus.regwrite_m = 1'b0; bus.writereg_m = 5'd12;
    bus.regwrite_w = 1'b0; bus.writereg_w = 5'd12;
    #1;
    chk("fwd_b_nowr", 32'(bus.fwd_b_e), 32'h0);

    // load-use: lw $9 in EX, rt_d = 9
    step();
    idle_inputs();
    bus.regwrite_e = 1'b1; bus.memtoreg_e = 1'b1; bus.writereg_e = 5'd9; bus.rt_d = 5'd9;
    #1;
    chk("lu_stall_f", 32'(bus.stall_f), 32'd1);
    chk("lu_stall_d", 32'(bus.stall_d), 32'd1);
    chk("lu_flush_e", 32'(bus.flush_e), 32'd1);
    chk("lu_flush_d", 32'(bus.flush_d), 32'd0);
    // bubble now in EX: hazard clears
    step();
    bus.regwrite_e = 1'b0; bus.memtoreg_e = 1'b0; bus.writereg_e = 5'd0;
    #1;
    chk("lu_clr_stall_f", 32'(bus.stall_f), 32'd0);
    chk("lu_clr_flush_e", 32'(bus.flush_e), 32'd0);
    // load into $0 is not a hazard
    step();
    bus.regwrite_e = 1'b1; bus.memtoreg_e = 1'b1; bus.writereg_e = 5'd0; bus.rs_d = 5'd0;
    #1;
    chk("lu_r0_stall_f", 32'(bus.stall_f), 32'd0);

    // branch with a simultaneous load-use
    step();
    bus.writereg_e = 5'd9; bus.rt_d = 5'd9; bus.branch_taken_m = 1'b1;
    #1;
    chk("br_flush_d", 32'(bus.flush_d), 32'd1);
    chk("br_flush_e", 32'(bus.flush_e), 32'd1);
    chk("br_flush_m", 32'(bus.flush_m), 32'd1);
    chk("br_stall_f", 32'(bus.stall_f), 32'd0);
    chk("br_stall_d", 32'(bus.stall_d), 32'd0);

    // halt word blocked by a load-use in the same cycle
    step();
    bus.branch_taken_m = 1'b0; bus.instr_d = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    #1;
    chk("halt_lu_blocked", 32'(bus.stall_f), 32'd0);

    // halt: flush_e on the request cycle, then three drain cycles
    step();
    bus.instr_d = 32'hFFFF_FFFF;
    #1;
    chk("halt_req_flush_e", 32'(bus.flush_e), 32'd1);
    chk("halt_req_halted",  32'(bus.halted),  32'd0);
    step();
    bus.instr_d = 32'h0;
    #1;
    chk("drain1_stall_f", 32'(bus.stall_f), 32'd1);
    chk("drain1_flush_d", 32'(bus.flush_d), 32'd1);
    chk("drain1_halted",  32'(bus.halted),  32'd0);
    step();
    chk("drain2_halted", 32'(bus.halted), 32'd0);
    step();
    chk("drain3_halted", 32'(bus.halted), 32'd0);
    chk("drain3_stall_f", 32'(bus.stall_f), 32'd1);
    step();
    chk("halted",        32'(bus.halted),  32'd1);
    chk("halted_stall_f", 32'(bus.stall_f), 32'd1);
    chk("halted_stall_d", 32'(bus.stall_d), 32'd1);
    chk("halted_flush_m", 32'(bus.flush_m), 32'd1);
    step();
    chk("halted_sticky", 32'(bus.halted), 32'd1);

    // asynchronous reset inside a clock phase
    #1;
    RESET = 1'b1;
    #1;
    chk("arst_halted",  32'(bus.halted),  32'd0);
    chk("arst_stall_f", 32'(bus.stall_f), 32'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("arst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("arst_flush_cnt", bus.flush_cnt, 32'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;

    // abort: branch on the second drain cycle
    bus.instr_d = 32'hFFFF_FFFF;
    step();
    bus.instr_d = 32'h0;
    #1;
    chk("abort_drain1", 32'(bus.stall_f), 32'd1);
    step();
    bus.branch_taken_m = 1'b1;
    #1;
    chk("abort_br_stall_f", 32'(bus.stall_f), 32'd0);
    chk("abort_br_flush_m", 32'(bus.flush_m), 32'd1);
    step();
    bus.branch_taken_m = 1'b0;
    #1;
    chk("abort_run_stall_f", 32'(bus.stall_f), 32'd0);
    chk("abort_run_flush_d", 32'(bus.flush_d), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_never_halted", 32'(bus.halted), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
